fifo_write_arbiter: RTL and testbench

- Write-side scheduler on wclk that shares the single enqueue port of the clock-crossing SyncFIFO among NUM_REQ producers.
- Grants are round-robin, in fixed bursts of FETCH_WIDTH words. Each group the downstream aggregator packs therefore always comes from one producer and is never interleaved.
- Sits between the producer blocks and the SyncFIFO sENQ/sD_IN/sFULL_N interface.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fifo_write_arbiter_rr_pick.sv | 24 ++
 rtl/fifo_write_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions used by the FIFO write arbiter, the aggregator and their benches.
package fetch_pkg;
   localparam int FETCH_DATA_WIDTH  = 8;
   localparam int FETCH_WIDTH_DEF   = 2;
   localparam int FETCH_MAX_REQ     = 8;

   typedef enum logic {IDLE, BURST} fetch_state_t;

   // Wide enough for the largest supported requester count.
   typedef logic [$clog2(FETCH_MAX_REQ)-1:0] grant_idx_t;
endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of req_mask scanning last_gnt+1, last_gnt+2, ...
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_mask,
   input  logic [IW-1:0] last_gnt,
   output logic          found,
   output logic [IW-1:0] idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Scan from the farthest offset down so the nearest valid requester wins.
      for (int k = N; k >= 1; k--) begin
         int j;
         j = (int'(last_gnt) + k) % N;
         if (req_mask[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end
endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares the SyncFIFO enqueue port among NUM_REQ producers in round-robin bursts of FETCH_WIDTH words.
module fifo_write_arbiter
   import fetch_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = FETCH_DATA_WIDTH,
   parameter int FETCH_WIDTH = FETCH_WIDTH_DEF,
   parameter int CNT_WIDTH   = 16,
   localparam int GW = $clog2(NUM_REQ),
   localparam int BW = $clog2(FETCH_WIDTH+1)
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic                          enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic                          fifo_enq,
   input  logic                          fifo_full_n,
   output logic [GW-1:0]                 grant_id,
   output logic                          busy,
   output logic [BW-1:0]                 beat_cnt,
   output logic [CNT_WIDTH-1:0]          enq_count
);
   fetch_state_t         r_state, w_state_nx;
   logic [GW-1:0]        r_grant, w_grant_nx;
   logic [GW-1:0]        r_last,  w_last_nx;
   logic [BW-1:0]        r_beat,  w_beat_nx;
   logic [CNT_WIDTH-1:0] r_cnt,   w_cnt_nx;

   logic                  w_busy, w_enq, w_found;
   logic [GW-1:0]         w_base, w_idx;
   logic [DATA_WIDTH-1:0] w_lane [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      assign w_lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   assign w_busy    = (r_state == BURST);
   assign w_enq     = w_busy && fifo_full_n && req_valid[r_grant];
   assign req_ready = (w_busy && fifo_full_n) ? (NUM_REQ'(1) << r_grant) : '0;
   assign fifo_enq  = w_enq;
   assign fifo_din  = w_lane[r_grant];
   assign grant_id  = r_grant;
   assign busy      = w_busy;
   assign beat_cnt  = r_beat;
   assign enq_count = r_cnt;

   // In BURST the picker is only consumed on the last beat, where the scan starts after the current grant.
   assign w_base = w_busy ? r_grant : r_last;

   rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
      .req_mask (req_valid),
      .last_gnt (w_base),
      .found    (w_found),
      .idx      (w_idx)
   );

   always_comb begin
      w_state_nx = r_state;
      w_grant_nx = r_grant;
      w_last_nx  = r_last;
      w_beat_nx  = r_beat;
      w_cnt_nx   = w_enq ? r_cnt + CNT_WIDTH'(1) : r_cnt;
      case (r_state)
         IDLE: begin
            if (enable && w_found) begin
               w_grant_nx = w_idx;
               w_beat_nx  = '0;
               w_state_nx = BURST;
            end
         end
         BURST: begin
            if (w_enq) begin
               w_beat_nx = r_beat + BW'(1);
               if (r_beat == BW'(FETCH_WIDTH-1)) begin
                  w_last_nx = r_grant;
                  w_beat_nx = '0;
                  if (enable && w_found) w_grant_nx = w_idx;
                  else                   w_state_nx = IDLE;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_last  <= GW'(NUM_REQ-1);
         r_beat  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_grant <= w_grant_nx;
         r_last  <= w_last_nx;
         r_beat  <= w_beat_nx;
         r_cnt   <= w_cnt_nx;
      end
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (NUM_REQ=4, FETCH_WIDTH=2, CNT_WIDTH=4 so the counter wrap is reachable).
module tb_fifo_write_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int FW = 2;
   localparam int CW = 4;

   logic           wclk = 1'b0;
   logic           wrst_n, enable, fifo_full_n;
   logic [NR-1:0]  req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]  req_ready;
   logic [DW-1:0]  fifo_din;
   logic           fifo_enq, busy;
   logic [1:0]     grant_id;
   logic [1:0]     beat_cnt;
   logic [CW-1:0]  enq_count;

   int n_cmp = 0;
   int n_bad = 0;

   fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FETCH_WIDTH(FW), .CNT_WIDTH(CW)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .enable(enable), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_din(fifo_din), .fifo_enq(fifo_enq), .fifo_full_n(fifo_full_n),
      .grant_id(grant_id), .busy(busy), .beat_cnt(beat_cnt), .enq_count(enq_count)
   );

   always #5 wclk = ~wclk;

   // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge wclk); #1;
   endtask

   task automatic do_reset();
      wrst_n = 1'b0; enable = 1'b0; fifo_full_n = 1'b1; req_valid = '0; req_data = '0;
      tick(); tick();
      wrst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      enable = 1'b1; req_valid = 4'hF; #1;
      n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL reset_busy: got %0h want 0", busy); end
      n_cmp++; if (grant_id !== 2'd0)     begin n_bad++; $display("FAIL reset_grant: got %0h want 0", grant_id); end
      n_cmp++; if (beat_cnt !== 2'd0)     begin n_bad++; $display("FAIL reset_beat: got %0h want 0", beat_cnt); end
      n_cmp++; if (enq_count !== 4'd0)    begin n_bad++; $display("FAIL reset_cnt: got %0h want 0", enq_count); end
      n_cmp++; if (req_ready !== 4'h0)    begin n_bad++; $display("FAIL reset_ready: got %0h want 0", req_ready); end
      n_cmp++; if (fifo_enq !== 1'b0)     begin n_bad++; $display("FAIL reset_enq: got %0h want 0", fifo_enq); end
   endtask

   task automatic test_single();
      do_reset();
      enable = 1'b1; req_valid = 4'b0100; req_data[2*DW +: DW] = 8'd0; #1;
      n_cmp++; if (fifo_enq !== 1'b0) begin n_bad++; $display("FAIL single_lat: got %0h want 0", fifo_enq); end
      tick();
      for (int w = 0; w < 4; w++) begin
         req_data[2*DW +: DW] = DW'(w);
         if (w == 3) enable = 1'b0;
         #1;
         n_cmp++; if (fifo_enq !== 1'b1)    begin n_bad++; $display("FAIL single_enq%0d: got %0h want 1", w, fifo_enq); end
         n_cmp++; if (fifo_din !== DW'(w))  begin n_bad++; $display("FAIL single_din%0d: got %0h want %0h", w, fifo_din, w); end
         n_cmp++; if (grant_id !== 2'd2)    begin n_bad++; $display("FAIL single_gnt%0d: got %0h want 2", w, grant_id); end
         n_cmp++; if (beat_cnt !== 2'(w % 2)) begin n_bad++; $display("FAIL single_beat%0d: got %0h want %0h", w, beat_cnt, w % 2); end
         tick();
      end
      n_cmp++; if (enq_count !== 4'd4) begin n_bad++; $display("FAIL single_cnt: got %0h want 4", enq_count); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL single_idle: got %0h want 0", busy); end
   endtask

   task automatic test_round_robin();
      do_reset();
      enable = 1'b1; req_valid = 4'hF;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(8'h10 * i + 8'h5);
      tick();
      for (int c = 0; c < 10; c++) begin
         if (c == 9) enable = 1'b0;
         #1;
         n_cmp++; if (grant_id !== 2'((c / 2) % 4)) begin n_bad++; $display("FAIL rr_gnt%0d: got %0h want %0h", c, grant_id, (c / 2) % 4); end
         n_cmp++; if (fifo_enq !== 1'b1) begin n_bad++; $display("FAIL rr_enq%0d: got %0h want 1", c, fifo_enq); end
         n_cmp++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL rr_busy%0d: got %0h want 1", c, busy); end
         n_cmp++; if (fifo_din !== DW'(8'h10 * ((c / 2) % 4) + 8'h5)) begin n_bad++; $display("FAIL rr_din%0d: got %0h", c, fifo_din); end
         tick();
      end
      n_cmp++; if (enq_count !== 4'd10) begin n_bad++; $display("FAIL rr_cnt: got %0h want a", enq_count); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rr_idle: got %0h want 0", busy); end
   endtask

   task automatic test_backpressure();
      do_reset();
      enable = 1'b1; req_valid = 4'b0110;
      tick();
      #1;
      n_cmp++; if (grant_id !== 2'd1 || fifo_enq !== 1'b1) begin n_bad++; $display("FAIL bp_first: gnt %0h enq %0h want 1 1", grant_id, fifo_enq); end
      tick();
      fifo_full_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++; if (fifo_enq !== 1'b0)  begin n_bad++; $display("FAIL bp_enq%0d: got %0h want 0", c, fifo_enq); end
         n_cmp++; if (beat_cnt !== 2'd1)  begin n_bad++; $display("FAIL bp_beat%0d: got %0h want 1", c, beat_cnt); end
         n_cmp++; if (grant_id !== 2'd1)  begin n_bad++; $display("FAIL bp_gnt%0d: got %0h want 1", c, grant_id); end
         n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL bp_ready%0d: got %0h want 0", c, req_ready); end
         tick();
      end
      fifo_full_n = 1'b1; #1;
      n_cmp++; if (fifo_enq !== 1'b1 || req_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_resume: enq %0h ready %0h want 1 2", fifo_enq, req_ready); end
      tick();
      enable = 1'b0; #1;
      n_cmp++; if (grant_id !== 2'd2 || beat_cnt !== 2'd0) begin n_bad++; $display("FAIL bp_next: gnt %0h beat %0h want 2 0", grant_id, beat_cnt); end
      tick(); tick();
      n_cmp++; if (enq_count !== 4'd4 || busy !== 1'b0) begin n_bad++; $display("FAIL bp_end: cnt %0h busy %0h want 4 0", enq_count, busy); end
   endtask

   task automatic test_valid_gap();
      do_reset();
      enable = 1'b1; req_valid = 4'b1000;
      tick();
      req_valid = 4'b1001; #1;
      n_cmp++; if (grant_id !== 2'd3 || fifo_enq !== 1'b1) begin n_bad++; $display("FAIL gap_first: gnt %0h enq %0h want 3 1", grant_id, fifo_enq); end
      tick();
      req_valid = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (fifo_enq !== 1'b0)      begin n_bad++; $display("FAIL gap_enq%0d: got %0h want 0", c, fifo_enq); end
         n_cmp++; if (req_ready !== 4'b1000)  begin n_bad++; $display("FAIL gap_ready%0d: got %0h want 8", c, req_ready); end
         n_cmp++; if (beat_cnt !== 2'd1)      begin n_bad++; $display("FAIL gap_beat%0d: got %0h want 1", c, beat_cnt); end
         tick();
      end
      req_valid = 4'b1001; #1;
      n_cmp++; if (fifo_enq !== 1'b1 || req_ready !== 4'b1000) begin n_bad++; $display("FAIL gap_second: enq %0h ready %0h want 1 8", fifo_enq, req_ready); end
      tick();
      enable = 1'b0; #1;
      n_cmp++; if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin n_bad++; $display("FAIL gap_next: gnt %0h ready %0h want 0 1", grant_id, req_ready); end
      tick(); tick();
      n_cmp++; if (enq_count !== 4'd4) begin n_bad++; $display("FAIL gap_cnt: got %0h want 4", enq_count); end
   endtask

   task automatic test_enable();
      do_reset();
      enable = 1'b1; req_valid = 4'b0011;
      tick();
      enable = 1'b0; #1;
      n_cmp++; if (grant_id !== 2'd0 || fifo_enq !== 1'b1) begin n_bad++; $display("FAIL en_first: gnt %0h enq %0h want 0 1", grant_id, fifo_enq); end
      tick();
      n_cmp++; if (fifo_enq !== 1'b1 || beat_cnt !== 2'd1) begin n_bad++; $display("FAIL en_second: enq %0h beat %0h want 1 1", fifo_enq, beat_cnt); end
      tick();
      for (int c = 0; c < 3; c++) begin
         n_cmp++; if (busy !== 1'b0 || fifo_enq !== 1'b0) begin n_bad++; $display("FAIL en_hold%0d: busy %0h enq %0h want 0 0", c, busy, fifo_enq); end
         tick();
      end
      n_cmp++; if (enq_count !== 4'd2) begin n_bad++; $display("FAIL en_cnt: got %0h want 2", enq_count); end
      enable = 1'b1;
      tick();
      enable = 1'b0; #1;
      n_cmp++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_bad++; $display("FAIL en_regrant: gnt %0h busy %0h want 1 1", grant_id, busy); end
      tick(); tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      enable = 1'b1; req_valid = 4'hF;
      tick(); tick();
      n_cmp++; if (beat_cnt !== 2'd1 || enq_count !== 4'd1) begin n_bad++; $display("FAIL rst_pre: beat %0h cnt %0h want 1 1", beat_cnt, enq_count); end
      wrst_n = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0 || grant_id !== 2'd0 || beat_cnt !== 2'd0 || enq_count !== 4'd0 || fifo_enq !== 1'b0)
         begin n_bad++; $display("FAIL rst_mid: busy %0h gnt %0h beat %0h cnt %0h enq %0h want 0", busy, grant_id, beat_cnt, enq_count, fifo_enq); end
      wrst_n = 1'b1;
      tick();
      n_cmp++; if (grant_id !== 2'd0 || fifo_enq !== 1'b1 || enq_count !== 4'd0) begin n_bad++; $display("FAIL rst_after: gnt %0h enq %0h cnt %0h want 0 1 0", grant_id, fifo_enq, enq_count); end
   endtask

   task automatic test_wrap();
      do_reset();
      enable = 1'b1; req_valid = 4'b0010;
      tick();
      for (int w = 0; w < 16; w++) begin
         req_data[1*DW +: DW] = DW'(w);
         if (w == 15) enable = 1'b0;
         #1;
         n_cmp++; if (fifo_enq !== 1'b1 || fifo_din !== DW'(w)) begin n_bad++; $display("FAIL wrap_w%0d: enq %0h din %0h", w, fifo_enq, fifo_din); end
         if (w == 15) begin
            n_cmp++; if (enq_count !== 4'd15) begin n_bad++; $display("FAIL wrap_pre: got %0h want f", enq_count); end
         end
         tick();
      end
      n_cmp++; if (enq_count !== 4'd0) begin n_bad++; $display("FAIL wrap_cnt: got %0h want 0", enq_count); end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_valid_gap();
      test_enable();
      test_reset_mid_burst();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
